// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory unit: RISC-V funct3 codes, FSM states
// and the access size / legality decode used by the top and the lane aligner.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] size_log2;
    logic       is_signed;
  } access_t;

  // Doubleword and unsigned-word codes only exist when the memory word is 64 bits wide.
  function automatic access_t decode_access(input logic we, input logic [2:0] funct3,
                                            input int data_w);
    access_t acc;
    acc.size_log2 = funct3[1:0];
    acc.is_signed = ~funct3[2];
    if (we) begin
      acc.valid = ~funct3[2] && !((funct3 == F3_D) && (data_w == 32));
    end else begin
      acc.valid = (funct3 != 3'b111) &&
                  !(((funct3 == F3_D) || (funct3 == F3_WU)) && (data_w == 32));
    end
    return acc;
  endfunction

  function automatic logic misaligned(input logic [63:0] addr, input logic [1:0] size_log2);
    case (size_log2)
      2'd0:    return 1'b0;
      2'd1:    return addr[0];
      2'd2:    return |addr[1:0];
      default: return |addr[2:0];
    endcase
  endfunction

endpackage

// File: rtl/data_memory_unit_if.sv
// Request/response bus of the data memory unit; the core side is the master.
interface data_memory_unit_if #(
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [63:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: merges right-aligned store data into a memory word and
// extracts/extends load data from a memory word at a byte offset.
module dmem_lane_align #(
  parameter  int DATA_W = 64,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic [1:0]        size_log2_i,
  input  logic              is_signed_i,
  output logic [DATA_W-1:0] merged_o,
  output logic [DATA_W-1:0] load_o
);
  localparam int NB = DATA_W / 8;

  int                nbytes;
  int                off;
  logic              sign_bit;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    off    = int'(offset_i);
    nbytes = 1 << size_log2_i;
    if (nbytes > NB) nbytes = NB;

    merged_o = word_i;
    for (int b = 0; b < NB; b++) begin
      if ((b >= off) && (b < off + nbytes)) merged_o[b*8 +: 8] = wdata_i[(b-off)*8 +: 8];
    end

    // Bytes above the access size are refilled with the sign bit or zero.
    shifted  = word_i >> {offset_i, 3'b000};
    sign_bit = shifted[nbytes*8-1] & is_signed_i;
    load_o   = shifted;
    for (int b = 0; b < NB; b++) begin
      if (b >= nbytes) load_o[b*8 +: 8] = {8{sign_bit}};
    end
  end

endmodule

// File: rtl/data_memory_unit.sv
// Fixed-latency data memory: one request in flight, response LAT cycles after accept,
// with alignment/range/funct3 checking and byte-granular stores.
module data_memory_unit
  import data_mem_pkg::*;
#(
  parameter int    DATA_W    = 64,
  parameter int    DEPTH     = 64,
  parameter int    LAT       = 2,
  parameter string INIT_FILE = ""
) (
  input logic               clk,
  input logic               rst,
  data_memory_unit_if.slave bus
);
  localparam int OFF_W     = $clog2(DATA_W / 8);
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W     = (LAT > 2) ? $clog2(LAT - 1) : 1;
  localparam int WAIT_INIT = (LAT > 1) ? LAT - 2 : 0;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [63:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;

  logic              cur_we;
  logic [2:0]        cur_funct3;
  logic [63:0]       cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  access_t           acc;
  logic              cur_err;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] load_data;
  logic              enter_resp;
  logic              commit;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // With LAT==1 the access happens on the accept edge, so the live request is used.
  always_comb begin
    cur_we     = (state_q == ST_IDLE) ? bus.req_we     : we_q;
    cur_funct3 = (state_q == ST_IDLE) ? bus.req_funct3 : funct3_q;
    cur_addr   = (state_q == ST_IDLE) ? bus.req_addr   : addr_q;
    cur_wdata  = (state_q == ST_IDLE) ? bus.req_wdata  : wdata_q;
    acc        = decode_access(cur_we, cur_funct3, DATA_W);
    cur_err    = !acc.valid || misaligned(cur_addr, acc.size_log2) ||
                 ((cur_addr >> OFF_W) >= 64'(DEPTH));
    mem_idx    = cur_addr[OFF_W +: IDX_W];
    enter_resp = ((state_q == ST_IDLE) && bus.req_valid && (LAT == 1)) ||
                 ((state_q == ST_WAIT) && (cnt_q == '0));
    commit     = enter_resp && cur_we && !cur_err && !rst;
  end

  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .word_i      (mem[mem_idx]),
    .wdata_i     (cur_wdata),
    .offset_i    (cur_addr[OFF_W-1:0]),
    .size_log2_i (acc.size_log2),
    .is_signed_i (acc.is_signed),
    .merged_o    (merged),
    .load_o      (load_data)
  );

  always_ff @(posedge clk) begin
    if (commit) mem[mem_idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            cnt_q    <= CNT_W'(WAIT_INIT);
            state_q  <= (LAT == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else             state_q <= ST_RESP;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      // Response registers are loaded on the same edge that performs the access.
      if (enter_resp) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= cur_err;
        resp_rdata_q <= (!cur_we && !cur_err) ? load_data : '0;
      end else begin
        resp_valid_q <= 1'b0;
        resp_err_q   <= 1'b0;
        resp_rdata_q <= '0;
      end
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule
